// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin shared binary-to-Gray converter; optional Gray-to-binary under GRAY2BIN_EN
module gray_conv_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]       req_mode,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [IDW-1:0]        out_id,
   output logic                  busy,
   output logic [15:0]           conv_count
);

   typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   grant;
   logic             found;
   logic [WIDTH-1:0] op;
   logic [IDW-1:0]   id;
   logic             accept;
   logic             conv_done;

   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            grant = IDW'(idx);
         end
      end
   end

   assign accept = (state == IDLE) && found;
   assign busy   = (state != IDLE);

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

`ifdef GRAY2BIN_EN
   localparam int BCW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
   logic             mode;
   logic [BCW-1:0]   bit_cnt;
   logic [WIDTH-1:0] res, res_nxt;

   // One Gray-to-binary bit per cycle, MSB already seeded into res at accept.
   always_comb begin
      res_nxt = res;
      for (int k = 0; k < WIDTH - 1; k++)
         if (k == int'(bit_cnt)) res_nxt[k] = res_nxt[k+1] ^ op[k];
   end

   assign conv_done = !mode || (bit_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode    <= 1'b0;
         bit_cnt <= '0;
         res     <= '0;
      end else if (accept) begin
         mode           <= req_mode[grant];
         bit_cnt        <= BCW'((WIDTH > 1) ? WIDTH - 2 : 0);
         res            <= '0;
         res[WIDTH-1]   <= req_data[int'(grant)*WIDTH + WIDTH - 1];
      end else if (state == CONVERT && mode) begin
         res <= res_nxt;
         if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
      end
   end
`else
   logic unused_mode;
   assign unused_mode = ^req_mode;
   assign conv_done   = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CONVERT;
         CONVERT: if (conv_done) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         op         <= '0;
         id         <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_id     <= '0;
         conv_count <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op     <= req_data[int'(grant)*WIDTH +: WIDTH];
            id     <= grant;
            rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
         end
         if (state == CONVERT && conv_done) begin
            out_id    <= id;
            out_valid <= 1'b1;
`ifdef GRAY2BIN_EN
            out_data  <= mode ? res_nxt : (op ^ (op >> 1));
`else
            out_data  <= op ^ (op >> 1);
`endif
         end
         if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
            if (conv_count != 16'hFFFF) conv_count <= conv_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - directed self-checking bench for gray_conv_arbiter (WIDTH=4, NREQ=4)
module tb_gray_conv_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_mode;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic [1:0]  out_id;
   logic        busy;
   logic [15:0] conv_count;

   int checks = 0;
   int errors = 0;

   logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
   logic [3:0] rr_gray [4]  = '{4'hA, 4'h5, 4'hD, 4'h2};

   gray_conv_arbiter #(.WIDTH(4), .NREQ(4), .IDW(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_mode(req_mode), .req_ready(req_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
      .busy(busy), .conv_count(conv_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_data = '0; req_mode = '0; out_ready = 1'b0;
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_id", out_id, 0);
      check("rst_busy", busy, 0);
      check("rst_count", conv_count, 0);
      check("rst_ready", req_ready, 0);
      rst_n = 1'b1;
      tick();
      check("idle_no_req_busy", busy, 0);

      // 1: single conversion
      req_valid = 4'b0001; req_data = 16'h000B; out_ready = 1'b1;
      #1 check("t1_ready", req_ready, 4'b0001);
      tick();
      check("t1_busy_conv", busy, 1);
      check("t1_valid_early", out_valid, 0);
      check("t1_ready_conv", req_ready, 0);
      req_valid = '0;
      tick();
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 4'b1110);
      check("t1_id", out_id, 0);
      tick();
      check("t1_valid_drop", out_valid, 0);
      check("t1_count", conv_count, 1);
      check("t1_idle", busy, 0);

      // 2: round robin with all requesting
      do_reset();
      check("t2_count_rst", conv_count, 0);
      req_valid = 4'b1111; req_data = 16'h396C; out_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         #1 check($sformatf("t2_ready_%0d", n), req_ready, 4'b0001 << (n % 4));
         tick(); tick();
         check($sformatf("t2_id_%0d", n), out_id, n % 4);
         check($sformatf("t2_data_%0d", n), out_data, rr_gray[n % 4]);
         tick();
      end
      check("t2_count", conv_count, 5);

      // 3: backpressure
      out_ready = 1'b0;
      tick(); tick();
      for (int n = 0; n < 5; n++) begin
         check($sformatf("t3_valid_%0d", n), out_valid, 1);
         check($sformatf("t3_data_%0d", n), out_data, 4'h5);
         check($sformatf("t3_id_%0d", n), out_id, 1);
         check($sformatf("t3_ready_%0d", n), req_ready, 0);
         check($sformatf("t3_busy_%0d", n), busy, 1);
         tick();
      end
      out_ready = 1'b1; req_valid = '0;
      tick();
      check("t3_count", conv_count, 6);

      // 4: async reset during HOLD
      req_valid = 4'b0100; out_ready = 1'b0;
      tick(); tick();
      check("t4_hold_id", out_id, 2);
      rst_n = 1'b0;
      #1;
      check("t4_rst_valid", out_valid, 0);
      check("t4_rst_busy", busy, 0);
      #2 rst_n = 1'b1;
      req_valid = 4'b0101; out_ready = 1'b1;
      #1 check("t4_ready", req_ready, 4'b0001);
      tick(); tick();
      check("t4_id", out_id, 0);
      req_valid = '0;
      tick();

`ifdef GRAY2BIN_EN
      // 5: serial Gray-to-binary
      do_reset();
      req_mode = 4'b0010; req_valid = 4'b0010; req_data = 16'h00E0;
      #1 check("t5_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      tick();
      check("t5_conv1", out_valid, 0);
      check("t5_busy", busy, 1);
      tick();
      check("t5_conv2", out_valid, 0);
      tick();
      check("t5_valid", out_valid, 1);
      check("t5_data", out_data, 4'b1011);
      check("t5_id", out_id, 1);
      tick();
      req_mode = '0;
`endif

      // 6: exhaustive via requester 3
      do_reset();
      out_ready = 1'b1;
      for (int b = 0; b < 16; b++) begin
         req_valid = 4'b1000; req_data = 16'(b) << 12;
         #1 check($sformatf("t6_ready_%0d", b), req_ready, 4'b1000);
         tick();
         req_valid = '0;
         tick();
         check($sformatf("t6_data_%0d", b), out_data, gray_tab[b]);
         check($sformatf("t6_id_%0d", b), out_id, 3);
         tick();
      end
      check("t6_count", conv_count, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
